// File: rtl/counter_seq_pkg.sv
// Shared types and helpers for the counter sequencing arbiter.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Width of a requester index; never below one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_seq_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr wins,
// wrapping around; produces a one-hot grant and its encoded index.
module rr_arbiter
  import counter_seq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] first;

  // rot[k] is the request of requester (ptr + k) mod NREQ.
  assign rot = NREQ'({req, req} >> ptr);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_first
      if (gi == 0) begin : g_lsb
        assign first[gi] = rot[0];
      end else begin : g_rest
        assign first[gi] = rot[gi] & ~|rot[gi-1:0];
      end
    end
  endgenerate

  // Rotate the rotated-domain winner back to absolute requester numbering.
  assign grant = NREQ'(({first, first} << ptr) >> NREQ);

  always_comb begin
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) idx = IDW'(k);
    end
  end

endmodule

// File: rtl/counter_seq_arbiter.sv
// Shares one up/down counter among NREQ requesters, stepping it to each target.
// Build option: COUNTER_SEQ_SHORTEST_EN selects the shorter modular direction.
module counter_seq_arbiter
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREQ  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_target,
  output logic [NREQ-1:0]         req_ready,
  input  logic [WIDTH-1:0]        cnt_value,
  output logic                    cnt_start,
  output logic                    cnt_up,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id
);

  localparam int IDW = $clog2(NREQ);

  state_t           state_reg;
  logic [IDW-1:0]   ptr_reg;
  logic [IDW-1:0]   id_reg;
  logic [WIDTH-1:0] target_reg;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] tgt_slice [NREQ];
  logic             accept;
  logic             up_dir;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (grant_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign tgt_slice[gi] = req_target[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Grants are withheld while rst is high so nothing is accepted during reset.
  assign req_ready = (state_reg == IDLE && !rst) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

`ifdef COUNTER_SEQ_SHORTEST_EN
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] fwd_dist;
  assign fwd_dist = target_reg - cnt_value;
  assign up_dir   = (fwd_dist <= HALF);
`else
  assign up_dir = (target_reg > cnt_value);
`endif

  assign cnt_start = (state_reg == RUN) && (cnt_value != target_reg);
  assign cnt_up    = (state_reg == RUN) && up_dir;
  assign busy      = (state_reg == RUN) || (state_reg == DONE);
  assign done      = (state_reg == DONE);
  assign done_id   = (state_reg == DONE) ? id_reg : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      id_reg     <= '0;
      target_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            target_reg <= tgt_slice[grant_idx];
            id_reg     <= grant_idx;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          if (cnt_value == target_reg) state_reg <= DONE;
        end
        DONE: begin
          ptr_reg   <= (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_arbiter.sv
// Directed bench for counter_seq_arbiter with a behavioural 4-bit up/down counter.
module tb_counter_seq_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_target;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      cnt_value;
  logic                  cnt_start;
  logic                  cnt_up;
  logic                  busy;
  logic                  done;
  logic [0:0]            done_id;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Counter datapath shared with the DUT, cleared by the same rst.
  always_ff @(posedge clk) begin
    if (rst) cnt_value <= '0;
    else if (cnt_start) cnt_value <= cnt_up ? cnt_value + 1'b1 : cnt_value - 1'b1;
  end

  counter_seq_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .cnt_value  (cnt_value),
    .cnt_start  (cnt_start),
    .cnt_up     (cnt_up),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Requests one job, waits for accept, then follows it to the done pulse.
  task automatic job(input int id, input logic [3:0] tgt, input int exp_steps,
                     input logic exp_up, input string tag, output int waited);
    int cyc, starts, ups, done_cyc;
    logic [3:0] start_val;
    req_target[id*WIDTH +: WIDTH] = tgt;
    req_valid[id] = 1'b1;
    #1;
    waited = 0;
    while (!req_ready[id] && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    check({tag, " ready"}, 32'(req_ready), 32'(1 << id));
    start_val = cnt_value;
    @(negedge clk);
    req_valid[id] = 1'b0;
    cyc = 1; starts = 0; ups = 0; done_cyc = -1;
    while (done_cyc < 0 && cyc < 40) begin
      if (cnt_start) begin
        starts++;
        if (cnt_up) ups++;
      end
      if (done) begin
        done_cyc = cyc;
        check({tag, " done_id"}, 32'(done_id), 32'(id));
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " steps"}, starts, exp_steps);
    check({tag, " up_steps"}, ups, exp_up ? exp_steps : 0);
    check({tag, " done_cycle"}, done_cyc, exp_steps + 2);
    check({tag, " cnt_value"}, 32'(cnt_value), 32'(tgt));
    check({tag, " done_pulse_len"}, 32'(done), 32'd0);
    $display("job %s: id=%0d %0d->%0d steps=%0d up=%0d done_cycle=%0d", tag, id,
             start_val, tgt, starts, ups, done_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst = 1'b1;
    req_valid = '0;
    req_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst cnt_start", 32'(cnt_start), 32'd0);
    check("rst cnt_up", 32'(cnt_up), 32'd0);
    check("rst done_id", 32'(done_id), 32'd0);
    rst = 1'b0;
    #1;
    check("idle no_req ready", 32'(req_ready), 32'd0);

    // 1: 0 -> 5 upward, done at cycle 7
    job(0, 4'd5, 5, 1'b1, "t1", w);
    // 2: reach 9, then requester 1 goes 9 -> 3 downward
    job(0, 4'd9, 4, 1'b1, "t2_setup", w);
    job(1, 4'd3, 6, 1'b0, "t2", w);

    // 3: simultaneous requests with pointer at 0
    req_target[WIDTH +: WIDTH] = 4'd8;
    req_valid[1] = 1'b1;
    job(0, 4'd6, 3, 1'b1, "t3_tie_a", w);
    job(1, 4'd8, 2, 1'b1, "t3_loser", w);
    check("t3 loser first idle", w, 0);
    req_target[WIDTH +: WIDTH] = 4'd7;
    req_valid[1] = 1'b1;
    job(0, 4'd4, 4, 1'b0, "t3_tie_b", w);
    job(1, 4'd7, 3, 1'b1, "t3_loser_b", w);

    // 4: target equals current value
    job(0, 4'd7, 0, 1'b0, "t4", w);

    // 5: reset two steps into a 0 -> 10 job
    job(1, 4'd0, 7, 1'b0, "t5_setup", w);
    req_target[0 +: WIDTH] = 4'd10;
    req_valid[0] = 1'b1;
    #1;
    check("t5 ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("t5 cnt mid", 32'(cnt_value), 32'd2);
    check("t5 busy mid", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5 busy after rst", 32'(busy), 32'd0);
    check("t5 done after rst", 32'(done), 32'd0);
    check("t5 start after rst", 32'(cnt_start), 32'd0);
    check("t5 cnt after rst", 32'(cnt_value), 32'd0);
    check("t5 ready in rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("t5 reaccept ready", 32'(req_ready), 32'd1);
    $display("reset abandoned job; requester 0 still pending");
    job(0, 4'd10, 10, 1'b1, "t5_rerun", w);

    // 6: 14 -> 1
    job(1, 4'd14, 4, 1'b1, "t6_setup", w);
`ifdef COUNTER_SEQ_SHORTEST_EN
    job(0, 4'd1, 3, 1'b1, "t6", w);
`else
    job(0, 4'd1, 13, 1'b0, "t6", w);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
